// File: rtl/tcdm_master_adapter.sv
// Per-initiator front end for one tcdm_interconnect initiator port.
// Request FIFO -> req/gnt issue, a tag FIFO tracking in-flight response kinds,
// and a response FIFO offered to the core under valid/ready. A credit counter
// bounds granted-but-unretired requests so the response FIFO cannot overflow.
module tcdm_master_adapter #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned BeWidth        = DataWidth / 8,
  parameter int unsigned ReqDepth       = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter bit          WriteRespOn    = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // Core request stream
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_wen_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  // Core response stream
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_wen_o,
  // Interconnect side
  output logic                 req_o,
  input  logic                 gnt_i,
  output logic [AddrWidth-1:0] add_o,
  output logic                 wen_o,
  output logic [DataWidth-1:0] wdata_o,
  output logic [BeWidth-1:0]   be_o,
  input  logic                 vld_i,
  input  logic [DataWidth-1:0] rdata_i,
  // Status
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned ReqPtrW = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
  localparam int unsigned ReqCntW = $clog2(ReqDepth + 1);
  localparam int unsigned RspPtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);

  localparam logic [ReqPtrW-1:0] ReqLast = ReqPtrW'(ReqDepth - 1);
  localparam logic [RspPtrW-1:0] RspLast = RspPtrW'(MaxOutstanding - 1);
  localparam logic [ReqCntW-1:0] ReqFull = ReqCntW'(ReqDepth);
  localparam logic [CntW-1:0]    RspFull = CntW'(MaxOutstanding);

  // Request FIFO storage and pointers
  logic [AddrWidth-1:0] req_addr_q  [ReqDepth];
  logic                 req_wen_q   [ReqDepth];
  logic [DataWidth-1:0] req_wdata_q [ReqDepth];
  logic [BeWidth-1:0]   req_be_q    [ReqDepth];
  logic [ReqPtrW-1:0]   req_wptr_q, req_wptr_d, req_rptr_q, req_rptr_d;
  logic [ReqCntW-1:0]   req_cnt_q, req_cnt_d;

  // Tag FIFO: wen of each granted request still awaiting vld_i
  logic                 tag_q [MaxOutstanding];
  logic [RspPtrW-1:0]   tag_wptr_q, tag_wptr_d, tag_rptr_q, tag_rptr_d;
  logic [CntW-1:0]      tag_cnt_q, tag_cnt_d;

  // Response FIFO
  logic [DataWidth-1:0] rsp_data_q [MaxOutstanding];
  logic                 rsp_tag_q  [MaxOutstanding];
  logic [RspPtrW-1:0]   rsp_wptr_q, rsp_wptr_d, rsp_rptr_q, rsp_rptr_d;
  logic [CntW-1:0]      rsp_cnt_q, rsp_cnt_d;

  // Credits: granted requests that need a response and are not yet retired
  logic [CntW-1:0]      outstanding_q, outstanding_d;
  logic                 err_q, err_d;

  logic req_empty, req_full, req_push, req_pop;
  logic head_wen, needs_rsp, grant;
  logic tag_empty, tag_push, tag_pop, spurious;
  logic rsp_empty, rsp_full, rsp_push, rsp_wr, rsp_pop, overflow;

  assign req_empty = (req_cnt_q == '0);
  assign req_full  = (req_cnt_q == ReqFull);
  assign req_push  = req_valid_i && !req_full;

  assign head_wen  = req_wen_q[req_rptr_q];
  assign needs_rsp = !head_wen || WriteRespOn;
  // Built only from registered state so gnt_i may depend on req_o
  assign req_o     = !req_empty && (!needs_rsp || (outstanding_q < RspFull));
  assign grant     = req_o && gnt_i;
  assign req_pop   = grant;

  assign tag_empty = (tag_cnt_q == '0);
  assign tag_push  = grant && needs_rsp;
  assign tag_pop   = vld_i && !tag_empty;
  assign spurious  = vld_i && tag_empty;

  assign rsp_empty = (rsp_cnt_q == '0);
  assign rsp_full  = (rsp_cnt_q == RspFull);
  assign rsp_push  = tag_pop;
  assign rsp_wr    = rsp_push && !rsp_full;
  assign overflow  = rsp_push && rsp_full;
  assign rsp_pop   = !rsp_empty && rsp_ready_i;

  // Head/data outputs read as zero while their FIFO is empty
  assign req_ready_o = !req_full;
  assign add_o       = req_empty ? '0 : req_addr_q[req_rptr_q];
  assign wen_o       = req_empty ? 1'b0 : head_wen;
  assign wdata_o     = req_empty ? '0 : req_wdata_q[req_rptr_q];
  assign be_o        = req_empty ? '0 : req_be_q[req_rptr_q];
  assign rsp_valid_o = !rsp_empty;
  assign rsp_rdata_o = rsp_empty ? '0 : rsp_data_q[rsp_rptr_q];
  assign rsp_wen_o   = rsp_empty ? 1'b0 : rsp_tag_q[rsp_rptr_q];
  assign busy_o      = !req_empty || (outstanding_q != '0);
  assign err_o       = err_q;

  // Next-state for pointers, occupancy counts, credits and the sticky error
  always_comb begin
    req_wptr_d    = req_wptr_q;
    req_rptr_d    = req_rptr_q;
    tag_wptr_d    = tag_wptr_q;
    tag_rptr_d    = tag_rptr_q;
    rsp_wptr_d    = rsp_wptr_q;
    rsp_rptr_d    = rsp_rptr_q;
    if (req_push) req_wptr_d = (req_wptr_q == ReqLast) ? '0 : req_wptr_q + 1'b1;
    if (req_pop)  req_rptr_d = (req_rptr_q == ReqLast) ? '0 : req_rptr_q + 1'b1;
    if (tag_push) tag_wptr_d = (tag_wptr_q == RspLast) ? '0 : tag_wptr_q + 1'b1;
    if (tag_pop)  tag_rptr_d = (tag_rptr_q == RspLast) ? '0 : tag_rptr_q + 1'b1;
    if (rsp_wr)   rsp_wptr_d = (rsp_wptr_q == RspLast) ? '0 : rsp_wptr_q + 1'b1;
    if (rsp_pop)  rsp_rptr_d = (rsp_rptr_q == RspLast) ? '0 : rsp_rptr_q + 1'b1;
    req_cnt_d     = req_cnt_q + ReqCntW'(req_push) - ReqCntW'(req_pop);
    tag_cnt_d     = tag_cnt_q + CntW'(tag_push) - CntW'(tag_pop);
    rsp_cnt_d     = rsp_cnt_q + CntW'(rsp_wr) - CntW'(rsp_pop);
    outstanding_d = outstanding_q + CntW'(tag_push) - CntW'(rsp_pop);
    err_d         = err_q || spurious || overflow;
  end

  // Control state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_wptr_q    <= '0;
      req_rptr_q    <= '0;
      req_cnt_q     <= '0;
      tag_wptr_q    <= '0;
      tag_rptr_q    <= '0;
      tag_cnt_q     <= '0;
      rsp_wptr_q    <= '0;
      rsp_rptr_q    <= '0;
      rsp_cnt_q     <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      req_wptr_q    <= req_wptr_d;
      req_rptr_q    <= req_rptr_d;
      req_cnt_q     <= req_cnt_d;
      tag_wptr_q    <= tag_wptr_d;
      tag_rptr_q    <= tag_rptr_d;
      tag_cnt_q     <= tag_cnt_d;
      rsp_wptr_q    <= rsp_wptr_d;
      rsp_rptr_q    <= rsp_rptr_d;
      rsp_cnt_q     <= rsp_cnt_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  // FIFO payload storage; contents are only observed through occupancy-gated reads
  always_ff @(posedge clk_i) begin
    if (req_push) begin
      req_addr_q[req_wptr_q]  <= req_addr_i;
      req_wen_q[req_wptr_q]   <= req_wen_i;
      req_wdata_q[req_wptr_q] <= req_wdata_i;
      req_be_q[req_wptr_q]    <= req_be_i;
    end
    if (tag_push) tag_q[tag_wptr_q] <= head_wen;
    if (rsp_wr) begin
      rsp_data_q[rsp_wptr_q] <= rdata_i;
      rsp_tag_q[rsp_wptr_q]  <= tag_q[tag_rptr_q];
    end
  end

endmodule

// File: tb/tb_tcdm_master_adapter.sv
// Bench for tcdm_master_adapter: directed vector table, hand-written corner
// sequences and a randomized run scored against a queue-based reference model.
module tb_tcdm_master_adapter;

  localparam int ReqD = 2;
  localparam int MaxO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_wen = 1'b0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_ready = 1'b0;
  logic        gnt = 1'b0;
  logic        vld = 1'b0;
  logic [31:0] rdata = '0;

  logic        d1_req_ready, d1_rsp_valid, d1_rsp_wen, d1_req_o, d1_wen, d1_busy, d1_err;
  logic [31:0] d1_rsp_rdata, d1_add, d1_wdata;
  logic [3:0]  d1_be;
  logic        d0_req_ready, d0_rsp_valid, d0_rsp_wen, d0_req_o, d0_wen, d0_busy, d0_err;
  logic [31:0] d0_rsp_rdata, d0_add, d0_wdata;
  logic [3:0]  d0_be;

  always #5 clk = ~clk;

  tcdm_master_adapter #(.ReqDepth(ReqD), .MaxOutstanding(MaxO), .WriteRespOn(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(d1_req_ready),
    .req_addr_i(req_addr), .req_wen_i(req_wen), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(d1_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(d1_rsp_rdata),
    .rsp_wen_o(d1_rsp_wen), .req_o(d1_req_o), .gnt_i(gnt), .add_o(d1_add), .wen_o(d1_wen),
    .wdata_o(d1_wdata), .be_o(d1_be), .vld_i(vld), .rdata_i(rdata), .busy_o(d1_busy),
    .err_o(d1_err)
  );

  tcdm_master_adapter #(.ReqDepth(ReqD), .MaxOutstanding(MaxO), .WriteRespOn(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(d0_req_ready),
    .req_addr_i(req_addr), .req_wen_i(req_wen), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(d0_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(d0_rsp_rdata),
    .rsp_wen_o(d0_rsp_wen), .req_o(d0_req_o), .gnt_i(gnt), .add_o(d0_add), .wen_o(d0_wen),
    .wdata_o(d0_wdata), .be_o(d0_be), .vld_i(vld), .rdata_i(rdata), .busy_o(d0_busy),
    .err_o(d0_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    logic        wen;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] mem_rdata;
    logic        exp_wen;
    logic [31:0] exp_rdata;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  bit   model_on = 0;
  bit   last_push = 0;
  int   d1_grants = 0;
  int   d0_grants = 0;
  bit   d0_rsp_seen = 0;
  int   pushed = 0;
  int   retired = 0;
  req_t mq[$];
  rsp_t inflight[$];
  rsp_t buffered[$];
  logic wen_log[$];
  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference-model comparison for one cycle of dut1 (WriteRespOn=1: everything needs credit)
  task automatic check_cycle(input bit retire);
    int outst;
    outst = inflight.size() + buffered.size();
    chk("req_ready", d1_req_ready, mq.size() < ReqD);
    chk("req_o", d1_req_o, (mq.size() > 0) && (outst < MaxO));
    chk("rsp_valid", d1_rsp_valid, buffered.size() > 0);
    chk("busy", d1_busy, (mq.size() > 0) || (outst > 0));
    chk("err_clear", d1_err, 0);
    if (mq.size() > 0) begin
      chk("add_o", d1_add, mq[0].addr);
      chk("wen_o", d1_wen, mq[0].wen);
      chk("wdata_o", d1_wdata, mq[0].wdata);
      chk("be_o", d1_be, mq[0].be);
    end
    if (retire) begin
      chk("rsp_expected", buffered.size() > 0, 1);
      if (buffered.size() > 0) begin
        chk("rsp_wen", d1_rsp_wen, buffered[0].wen);
        if (!buffered[0].wen) chk("rsp_rdata", d1_rsp_rdata, buffered[0].rdata);
        wen_log.push_back(d1_rsp_wen);
        retired++;
      end
    end
  endtask

  // One clock: observe handshakes before the edge, update model and responder after it
  task automatic step();
    bit   push, grant, retire;
    req_t r, g;
    rsp_t e;
    push   = req_valid && d1_req_ready;
    grant  = d1_req_o && gnt;
    retire = d1_rsp_valid && rsp_ready;
    if (grant) d1_grants++;
    if (d0_req_o && gnt) d0_grants++;
    if (d0_rsp_valid) d0_rsp_seen = 1;
    r = '{req_addr, req_wen, req_wdata, req_be};
    if (model_on) check_cycle(retire);
    @(posedge clk);
    #1;
    last_push = push;
    if (model_on) begin
      if (retire && buffered.size() > 0) void'(buffered.pop_front());
      if (vld && inflight.size() > 0) buffered.push_back(inflight.pop_front());
      if (grant && mq.size() > 0) begin
        g = mq.pop_front();
        e.wen = g.wen;
        e.rdata = $urandom;
        inflight.push_back(e);
        vld = 1'b1;
        rdata = e.rdata;
      end else begin
        vld = 1'b0;
        rdata = $urandom;
      end
      if (push) begin
        mq.push_back(r);
        pushed++;
      end
    end
  endtask

  task automatic push_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] b, input bit use0);
    bit ok;
    ok = 0;
    req_valid = 1'b1;
    req_addr = a;
    req_wen = w;
    req_wdata = d;
    req_be = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = use0 ? d0_req_ready : d1_req_ready;
      step();
    end
    req_valid = 1'b0;
    chk("push_accepted", ok, 1);
  endtask

  task automatic do_reset();
    model_on = 0;
    req_valid = 0; gnt = 0; vld = 0; rsp_ready = 0; rdata = '0;
    req_addr = '0; req_wen = 0; req_wdata = '0; req_be = '0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_req_o", d1_req_o, 0);
    chk("rst_rsp_valid", d1_rsp_valid, 0);
    chk("rst_busy", d1_busy, 0);
    chk("rst_req_ready", d1_req_ready, 1);
    chk("rst_err", d1_err, 0);
    chk("rst_add", d1_add, 0);
    chk("rst_wdata", d1_wdata, 0);
    chk("rst_be", d1_be, 0);
    chk("rst_wen", d1_wen, 0);
    chk("rst_rsp_rdata", d1_rsp_rdata, 0);
    chk("rst_rsp_wen", d1_rsp_wen, 0);
    chk("rst0_busy", d0_busy, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete(); inflight.delete(); buffered.delete(); wen_log.delete();
    d1_grants = 0; d0_grants = 0; d0_rsp_seen = 0; last_push = 0;
    pushed = 0; retired = 0;
  endtask

  initial begin
    logic exp_mixed[3];
    bit   acc;

    vecs[0] = '{32'h100, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{32'h204, 1'b1, 32'h12345678, 4'hF, 32'hCAFEF00D, 1'b1, 32'h0};
    vecs[2] = '{32'hFFFFFFFC, 1'b0, 32'h0, 4'h1, 32'h0000_00A5, 1'b0, 32'h0000_00A5};
    vecs[3] = '{32'h8, 1'b1, 32'hA5A5_5A5A, 4'h5, 32'h1111_2222, 1'b1, 32'h0};
    vecs[4] = '{32'h0, 1'b0, 32'h0, 4'hC, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF};

    // Directed single transactions, one per table row
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_addr = vecs[i].addr; req_wen = vecs[i].wen;
      req_wdata = vecs[i].wdata; req_be = vecs[i].be;
      chk("t_ready_before", d1_req_ready, 1);
      chk("t_req_o_idle", d1_req_o, 0);
      step();
      req_valid = 1'b0;
      chk("t_req_o_next", d1_req_o, 1);
      chk("t_add_o", d1_add, vecs[i].addr);
      chk("t_wen_o", d1_wen, vecs[i].wen);
      chk("t_wdata_o", d1_wdata, vecs[i].wdata);
      chk("t_be_o", d1_be, vecs[i].be);
      chk("t_busy", d1_busy, 1);
      gnt = 1'b1;
      step();
      gnt = 1'b0;
      chk("t_req_o_after_gnt", d1_req_o, 0);
      chk("t_no_bypass", d1_rsp_valid, 0);
      chk("t_busy_inflight", d1_busy, 1);
      vld = 1'b1;
      rdata = vecs[i].mem_rdata;
      step();
      vld = 1'b0;
      rdata = '0;
      chk("t_rsp_valid", d1_rsp_valid, 1);
      chk("t_rsp_wen", d1_rsp_wen, vecs[i].exp_wen);
      if (!vecs[i].exp_wen) chk("t_rsp_rdata", d1_rsp_rdata, vecs[i].exp_rdata);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("t_rsp_gone", d1_rsp_valid, 0);
      chk("t_idle", d1_busy, 0);
      chk("t_err", d1_err, 0);
    end

    // Credit stall: 6 loads, responses held back
    do_reset();
    model_on = 1;
    gnt = 1'b1;
    for (int i = 0; i < 6; i++) push_req(32'h1000 + 32'(4 * i), 1'b0, '0, 4'hF, 0);
    repeat (4) step();
    chk("cs_grants", d1_grants, 4);
    chk("cs_req_o_low", d1_req_o, 0);
    chk("cs_ready_low", d1_req_ready, 0);
    chk("cs_rsp_valid", d1_rsp_valid, 1);
    rsp_ready = 1'b1;
    repeat (20) step();
    chk("cs_grants_all", d1_grants, 6);
    chk("cs_retired", wen_log.size(), 6);
    foreach (wen_log[i]) chk("cs_wen", wen_log[i], 0);
    chk("cs_idle", d1_busy, 0);

    // Mixed load/store/load with grant held off for 3 cycles
    do_reset();
    model_on = 1;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr = 32'h40; req_wen = 1'b0; req_wdata = '0; req_be = 4'hF;
    step();
    req_addr = 32'h44; req_wen = 1'b1; req_wdata = 32'h55AA_55AA; req_be = 4'h3;
    step();
    req_addr = 32'h48; req_wen = 1'b0; req_wdata = '0; req_be = 4'hF;
    step();
    gnt = 1'b1;
    acc = 0;
    for (int i = 0; i < 10 && !acc; i++) begin
      acc = d1_req_ready;
      step();
    end
    req_valid = 1'b0;
    chk("mx_accepted", acc, 1);
    repeat (10) step();
    exp_mixed[0] = 1'b0; exp_mixed[1] = 1'b1; exp_mixed[2] = 1'b0;
    chk("mx_count", wen_log.size(), 3);
    for (int i = 0; i < 3 && i < wen_log.size(); i++) chk("mx_wen", wen_log[i], exp_mixed[i]);

    // Spurious response, then asynchronous reset in the middle of a burst
    do_reset();
    vld = 1'b1;
    step();
    vld = 1'b0;
    chk("sp_err_set", d1_err, 1);
    chk("sp_dropped", d1_rsp_valid, 0);
    req_valid = 1'b1; req_addr = 32'h300; req_wen = 1'b0; req_be = 4'hF;
    gnt = 1'b1;
    repeat (3) step();
    chk("sp_err_sticky", d1_err, 1);
    chk("sp_busy", d1_busy, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_err", d1_err, 0);
    chk("ar_req_o", d1_req_o, 0);
    chk("ar_busy", d1_busy, 0);
    chk("ar_req_ready", d1_req_ready, 1);
    chk("ar_rsp_valid", d1_rsp_valid, 0);
    chk("ar_add", d1_add, 0);
    req_valid = 1'b0;
    gnt = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vld = 1'b1;
    step();
    vld = 1'b0;
    chk("ar_stale_vld_err", d1_err, 1);

    // WriteRespOn=0 instance: stores need no credit and produce no response
    do_reset();
    gnt = 1'b1;
    for (int i = 0; i < 8; i++)
      push_req(32'h2000 + 32'(4 * i), 1'b1, 32'(i * 3 + 1), 4'hF, 1);
    repeat (4) step();
    chk("wr_grants", d0_grants, 8);
    chk("wr_no_rsp", d0_rsp_seen, 0);
    chk("wr_idle", d0_busy, 0);
    chk("wr_req_o", d0_req_o, 0);
    chk("wr_err", d0_err, 0);

    // Randomized traffic against the reference model
    do_reset();
    model_on = 1;
    for (int c = 0; c < 3000; c++) begin
      if (!req_valid || last_push) begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_addr = $urandom;
        req_wen = 1'($urandom_range(0, 1));
        req_wdata = $urandom;
        req_be = 4'($urandom_range(0, 15));
      end
      gnt = ($urandom_range(0, 2) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = 1'b0;
    gnt = 1'b1;
    rsp_ready = 1'b1;
    repeat (20) step();
    chk("rnd_no_loss", retired, pushed);
    chk("rnd_idle", d1_busy, 0);
    chk("rnd_err", d1_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
